// File: rtl/diff_commit_sequencer.sv
// Buffers up to two in-order retire commits per cycle and drains one per cycle into the
// single-lane difftest commit port. Defining DIFF_SEQ_STATS_EN adds commit/stall counters.
//
// state | meaning
// RUN   | accepting commits, draining when diff_ready
// FLUSH | no new commits, draining until empty
// DONE  | flush_done pulse, back to RUN next cycle
module diff_commit_sequencer #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            c0_valid,
    input  logic [XLEN-1:0] c0_pc,
    input  logic [31:0]     c0_instr,
    input  logic            c0_skip,
    input  logic            c0_wen,
    input  logic [7:0]      c0_wdest,
    input  logic [XLEN-1:0] c0_wdata,
    input  logic            c1_valid,
    input  logic [XLEN-1:0] c1_pc,
    input  logic [31:0]     c1_instr,
    input  logic            c1_skip,
    input  logic            c1_wen,
    input  logic [7:0]      c1_wdest,
    input  logic [XLEN-1:0] c1_wdata,
    output logic            in_ready,
    input  logic            diff_ready,
    input  logic            flush_req,
    output logic            flush_done,
    output logic            instrValid,
    output logic [7:0]      index,
    output logic [XLEN-1:0] the_pc,
    output logic [31:0]     instr,
    output logic            skip,
    output logic            wen,
    output logic [7:0]      wdest,
    output logic [XLEN-1:0] wdata,
    output logic            overflow_err
`ifdef DIFF_SEQ_STATS_EN
    ,
    output logic [31:0]     stat_commits,
    output logic [31:0]     stat_stalls
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - 2);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            skip;
        logic            wen;
        logic [7:0]      wdest;
        logic [XLEN-1:0] wdata;
    } rec_t;

    typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

    state_t        state_q, state_d;
    rec_t          fifo_mem [DEPTH];
    rec_t          out_q;
    rec_t          c0_rec, c1_rec;
    logic [AW-1:0] head_q, tail_q, c1_slot;
    logic [AW:0]   occ_q;
    logic [7:0]    seq_q;
    logic          offer, accept, pop;
    logic [1:0]    push_cnt;

    assign c0_rec   = {c0_pc, c0_instr, c0_skip, c0_wen, c0_wdest, c0_wdata};
    assign c1_rec   = {c1_pc, c1_instr, c1_skip, c1_wen, c1_wdest, c1_wdata};
    assign offer    = c0_valid | c1_valid;
    assign accept   = offer & in_ready;
    // occupancy is registered, so an entry pushed this cycle can never be popped this cycle
    assign pop      = (occ_q != '0) & diff_ready;
    assign push_cnt = accept ? ({1'b0, c0_valid} + {1'b0, c1_valid}) : 2'd0;
    assign c1_slot  = tail_q + AW'(c0_valid);

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        flush_done = 1'b0;
        case (state_q)
            RUN: begin
                in_ready = (occ_q <= READY_MAX);
                if (flush_req) state_d = FLUSH;
            end
            FLUSH: begin
                if (occ_q == '0) state_d = DONE;
            end
            DONE: begin
                flush_done = 1'b1;
                state_d    = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (accept && c0_valid) fifo_mem[tail_q]  <= c0_rec;
        if (accept && c1_valid) fifo_mem[c1_slot] <= c1_rec;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            occ_q        <= '0;
            seq_q        <= 8'd0;
            out_q        <= '0;
            instrValid   <= 1'b0;
            index        <= 8'd0;
            overflow_err <= 1'b0;
        end else begin
            tail_q     <= tail_q + AW'(push_cnt);
            occ_q      <= occ_q + (AW+1)'(push_cnt) - (AW+1)'(pop);
            instrValid <= pop;
            if (pop) begin
                out_q  <= fifo_mem[head_q];
                index  <= seq_q;
                seq_q  <= seq_q + 8'd1;
                head_q <= head_q + AW'(1);
            end
            if (offer && !in_ready) overflow_err <= 1'b1;
        end
    end

    assign the_pc = out_q.pc;
    assign instr  = out_q.instr;
    assign skip   = out_q.skip;
    assign wen    = out_q.wen;
    assign wdest  = out_q.wdest;
    assign wdata  = out_q.wdata;

`ifdef DIFF_SEQ_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_commits <= 32'd0;
            stat_stalls  <= 32'd0;
        end else begin
            if (pop && stat_commits != '1) stat_commits <= stat_commits + 32'd1;
            if (occ_q != '0 && !diff_ready && stat_stalls != '1) stat_stalls <= stat_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_diff_commit_sequencer.sv
// Randomized and directed bench for diff_commit_sequencer against a queue-based model.
module tb_diff_commit_sequencer;
    localparam int DEPTH = 8;
    localparam int XLEN  = 64;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        skip;
        logic        wen;
        logic [7:0]  wdest;
        logic [63:0] wdata;
    } rec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        c0_valid = 0, c0_skip = 0, c0_wen = 0;
    logic [63:0] c0_pc = 0, c0_wdata = 0;
    logic [31:0] c0_instr = 0;
    logic [7:0]  c0_wdest = 0;
    logic        c1_valid = 0, c1_skip = 0, c1_wen = 0;
    logic [63:0] c1_pc = 0, c1_wdata = 0;
    logic [31:0] c1_instr = 0;
    logic [7:0]  c1_wdest = 0;
    logic        diff_ready = 0, flush_req = 0;
    logic        in_ready, flush_done, instrValid, skip, wen, overflow_err;
    logic [7:0]  index, wdest;
    logic [63:0] the_pc, wdata;
    logic [31:0] instr;
`ifdef DIFF_SEQ_STATS_EN
    logic [31:0] stat_commits, stat_stalls;
`endif

    diff_commit_sequencer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock(clock), .reset(reset),
        .c0_valid(c0_valid), .c0_pc(c0_pc), .c0_instr(c0_instr), .c0_skip(c0_skip),
        .c0_wen(c0_wen), .c0_wdest(c0_wdest), .c0_wdata(c0_wdata),
        .c1_valid(c1_valid), .c1_pc(c1_pc), .c1_instr(c1_instr), .c1_skip(c1_skip),
        .c1_wen(c1_wen), .c1_wdest(c1_wdest), .c1_wdata(c1_wdata),
        .in_ready(in_ready), .diff_ready(diff_ready), .flush_req(flush_req),
        .flush_done(flush_done), .instrValid(instrValid), .index(index),
        .the_pc(the_pc), .instr(instr), .skip(skip), .wen(wen), .wdest(wdest),
        .wdata(wdata), .overflow_err(overflow_err)
`ifdef DIFF_SEQ_STATS_EN
        , .stat_commits(stat_commits), .stat_stalls(stat_stalls)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // model state: pending records, sequence number, mode (0 run, 1 flush, 2 done)
    rec_t        mq[$];
    logic [7:0]  mseq = 0;
    int          mmode = 0;
    bit          movf = 0, mvalid = 0;
    rec_t        mout = '0;
    logic [7:0]  midx = 0;
    logic [63:0] log_pc[$];
    logic [7:0]  log_idx[$];
    int          log_cyc[$];
    int          cyc_no = 0;

    always @(posedge clock) begin
        int   sz;
        bit   rdy;
        rec_t r0, r1;
        sz = mq.size();
        r0 = {c0_pc, c0_instr, c0_skip, c0_wen, c0_wdest, c0_wdata};
        r1 = {c1_pc, c1_instr, c1_skip, c1_wen, c1_wdest, c1_wdata};
        cyc_no++;
        if (reset) begin
            mq.delete();
            mseq = 0; mmode = 0; movf = 0; mvalid = 0; mout = '0; midx = 0;
        end else begin
            rdy    = (mmode == 0) && (sz <= DEPTH - 2);
            mvalid = (sz > 0) && diff_ready;
            if (mvalid) begin
                mout = mq.pop_front();
                midx = mseq;
                mseq = mseq + 8'd1;
            end
            if (rdy) begin
                if (c0_valid) mq.push_back(r0);
                if (c1_valid) mq.push_back(r1);
            end else if (c0_valid || c1_valid) movf = 1;
            case (mmode)
                0: if (flush_req) mmode = 1;
                1: if (sz == 0) mmode = 2;
                default: mmode = 0;
            endcase
        end
        #1;
        chk("instrValid", instrValid, mvalid);
        chk("index", index, midx);
        chk("the_pc", the_pc, mout.pc);
        chk("instr_skip_wen_wdest", {instr, skip, wen, wdest}, {mout.instr, mout.skip, mout.wen, mout.wdest});
        chk("wdata", wdata, mout.wdata);
        chk("in_ready", in_ready, (mmode == 0) && (mq.size() <= DEPTH - 2));
        chk("flush_done", flush_done, mmode == 2);
        chk("overflow_err", overflow_err, movf);
        if (instrValid) begin
            log_pc.push_back(the_pc);
            log_idx.push_back(index);
            log_cyc.push_back(cyc_no);
        end
    end

    task automatic set_lane(input int lane, input logic v, input logic [63:0] pc);
        if (lane == 0) begin
            c0_valid = v; c0_pc = pc; c0_instr = $urandom; c0_skip = 1'($urandom_range(0, 1));
            c0_wen = 1'($urandom_range(0, 1)); c0_wdest = 8'($urandom); c0_wdata = {$urandom, $urandom};
        end else begin
            c1_valid = v; c1_pc = pc; c1_instr = $urandom; c1_skip = 1'($urandom_range(0, 1));
            c1_wen = 1'($urandom_range(0, 1)); c1_wdest = 8'($urandom); c1_wdata = {$urandom, $urandom};
        end
    endtask

    task automatic idle();
        c0_valid = 0; c1_valid = 0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clr_log();
        log_pc.delete(); log_idx.delete(); log_cyc.delete();
    endtask

    task automatic do_reset();
        reset = 1; flush_req = 0; idle();
        cyc(2);
        reset = 0;
    endtask

    initial begin
        int mism;
        int fd;
        // reset state
        cyc(3);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_instrValid", instrValid, 0);
        chk("rst_index", index, 0);
        chk("rst_overflow", overflow_err, 0);
        reset = 0;

        // dual commit drains in order on consecutive cycles
        clr_log();
        diff_ready = 1;
        set_lane(0, 1, 64'h8000_0000);
        set_lane(1, 1, 64'h8000_0004);
        cyc(1); idle(); cyc(4);
        chk("dual_count", log_pc.size(), 2);
        chk("dual_pc0", log_pc[0], 64'h8000_0000);
        chk("dual_idx0", log_idx[0], 0);
        chk("dual_pc1", log_pc[1], 64'h8000_0004);
        chk("dual_idx1", log_idx[1], 1);
        chk("dual_back_to_back", log_cyc[1] - log_cyc[0], 1);

        // lane1 alone becomes a single entry
        do_reset(); clr_log();
        set_lane(0, 0, 64'h55);
        set_lane(1, 1, 64'h80);
        cyc(1); idle(); cyc(3);
        chk("c1only_count", log_pc.size(), 1);
        chk("c1only_pc", log_pc[0], 64'h80);
        chk("c1only_idx", log_idx[0], 0);

        // fill with diff_ready low, overflow on extra offer, then release
        do_reset();
        diff_ready = 0;
        for (int k = 0; k < 4; k++) begin
            set_lane(0, 1, 64'h1000 + 64'(16 * k));
            set_lane(1, 1, 64'h1008 + 64'(16 * k));
            cyc(1);
            if (k == 2) chk("fill_ready_at6", in_ready, 1);
        end
        idle();
        chk("fill_ready_at8", in_ready, 0);
        chk("fill_no_ovf_yet", overflow_err, 0);
        set_lane(0, 1, 64'h2000);
        set_lane(1, 1, 64'h2008);
        cyc(1); idle();
        chk("fill_ovf_set", overflow_err, 1);
        clr_log();
        diff_ready = 1;
        cyc(12);
        chk("fill_drain_count", log_pc.size(), 8);
        mism = 0;
        for (int i = 0; i < log_pc.size(); i++)
            if (log_pc[i] != 64'h1000 + 64'(8 * i)) mism++;
        chk("fill_drain_order", mism, 0);
        chk("fill_ovf_sticky", overflow_err, 1);

        // index wrap over 300 records
        do_reset(); clr_log();
        diff_ready = 1;
        for (int i = 0; i < 300; i++) begin
            set_lane(0, 1, 64'h4000 + 64'(4 * i));
            c1_valid = 0;
            cyc(1);
        end
        idle(); cyc(4);
        chk("wrap_count", log_pc.size(), 300);
        chk("wrap_idx255", log_idx[255], 255);
        chk("wrap_idx256", log_idx[256], 0);
        mism = 0;
        for (int i = 0; i < log_pc.size(); i++)
            if (log_pc[i] != 64'h4000 + 64'(4 * i)) mism++;
        chk("wrap_pc_contiguous", mism, 0);

        // flush handshake with diff_ready toggling
        do_reset();
        diff_ready = 0;
        set_lane(0, 1, 64'h6000);
        set_lane(1, 1, 64'h6004);
        cyc(1);
        set_lane(0, 1, 64'h6008);
        c1_valid = 0;
        cyc(1); idle();
        clr_log();
        flush_req = 1; diff_ready = 1;
        cyc(1);
        flush_req = 0;
        chk("flush_in_ready_low", in_ready, 0);
        fd = 0;
        for (int i = 0; i < 20; i++) begin
            diff_ready = (i % 2 == 1);
            cyc(1);
            if (flush_done) fd++;
        end
        chk("flush_records", log_pc.size(), 3);
        chk("flush_last_pc", log_pc[log_pc.size() - 1], 64'h6008);
        chk("flush_done_pulses", fd, 1);
        chk("flush_back_run", in_ready, 1);

        // reset with pending entries
        do_reset();
        diff_ready = 0;
        set_lane(0, 1, 64'h7000); set_lane(1, 1, 64'h7004); cyc(1);
        set_lane(0, 1, 64'h7008); set_lane(1, 1, 64'h700c); cyc(1);
        set_lane(0, 1, 64'h7010); c1_valid = 0; cyc(1);
        idle();
        reset = 1; diff_ready = 1;
        cyc(1);
        chk("rstmid_instrValid", instrValid, 0);
        chk("rstmid_in_ready", in_ready, 1);
        reset = 0;
        clr_log();
        set_lane(0, 1, 64'h9000);
        cyc(1); idle(); cyc(3);
        chk("rstmid_count", log_pc.size(), 1);
        chk("rstmid_idx", log_idx[0], 0);
        chk("rstmid_pc", log_pc[0], 64'h9000);

        // randomized traffic, checked every cycle by the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            set_lane(0, 1'($urandom_range(0, 1)), {$urandom, $urandom});
            set_lane(1, 1'($urandom_range(0, 1)), {$urandom, $urandom});
            diff_ready = ($urandom_range(0, 9) < 7);
            flush_req  = ($urandom_range(0, 49) == 0);
            reset      = ($urandom_range(0, 399) == 0);
            cyc(1);
        end
        idle(); flush_req = 0; reset = 0; diff_ready = 1;
        cyc(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
